// File: rtl/mtimer_client_if.sv
// mtimer_client_if: core-side request/response and timer-side register port of mtimer_client
interface mtimer_client_if;
  logic        req;
  logic        op;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] rdata;
  logic [1:0]  t_addr;
  logic        t_we;
  logic [31:0] t_din;
  logic [31:0] t_dout;
  modport slave (
    input  req, op, wdata, t_dout,
    output busy, done, err, rdata, t_addr, t_we, t_din
  );
  modport master (
    output req, op, wdata, t_dout,
    input  busy, done, err, rdata, t_addr, t_we, t_din
  );
endinterface

// File: rtl/mtimer_client.sv
// mtimer_client: tear-free 64-bit mtime reads and glitch-free 64-bit mtimecmp writes over a 32-bit timer port.
// Define MTIMER_CLIENT_READBACK_EN to read mtimecmp back after a write and flag mismatches in err.
module mtimer_client #(
  parameter int unsigned MAX_RETRY = 3
) (
  input logic            clk,
  input logic            resetn,
  mtimer_client_if.slave bus
);
`ifdef MTIMER_CLIENT_READBACK_EN
  typedef enum logic [3:0] {IDLE, RD_HI1, RD_LO, RD_HI2, WR_HMAX, WR_LO, WR_HI, VF_LO, VF_HI} state_e;
`else
  typedef enum logic [2:0] {IDLE, RD_HI1, RD_LO, RD_HI2, WR_HMAX, WR_LO, WR_HI} state_e;
`endif
  state_e      state_q, state_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic [31:0] hi1_q, hi1_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
`ifdef MTIMER_CLIENT_READBACK_EN
  logic        vf_err_q, vf_err_d;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      wdata_q  <= '0;
      rdata_q  <= '0;
      hi1_q    <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef MTIMER_CLIENT_READBACK_EN
      vf_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      hi1_q    <= hi1_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      done_q   <= done_d;
`ifdef MTIMER_CLIENT_READBACK_EN
      vf_err_q <= vf_err_d;
`endif
    end
  end
  always_comb begin
    state_d  = state_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    hi1_d    = hi1_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    done_d   = 1'b0;
`ifdef MTIMER_CLIENT_READBACK_EN
    vf_err_d = vf_err_q;
`endif
    case (state_q)
      IDLE: if (bus.req) begin
        wdata_d = bus.wdata;
        cnt_d   = '0;
        state_d = bus.op ? WR_HMAX : RD_HI1;
      end
      RD_HI1: begin
        hi1_d   = bus.t_dout;
        state_d = RD_LO;
      end
      RD_LO: begin
        lo_d    = bus.t_dout;
        state_d = RD_HI2;
      end
      // A stable high word proves lo was not torn by a carry; otherwise resample lo
      RD_HI2: if (bus.t_dout == hi1_q || cnt_q == 4'(MAX_RETRY)) begin
        rdata_d = {bus.t_dout, lo_q};
        err_d   = bus.t_dout != hi1_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        hi1_d   = bus.t_dout;
        cnt_d   = cnt_q + 4'd1;
        state_d = RD_LO;
      end
      WR_HMAX: state_d = WR_LO;
      WR_LO:   state_d = WR_HI;
`ifdef MTIMER_CLIENT_READBACK_EN
      WR_HI:   state_d = VF_LO;
      VF_LO: begin
        vf_err_d = bus.t_dout != wdata_q[31:0];
        state_d  = VF_HI;
      end
      VF_HI: begin
        err_d   = vf_err_q | (bus.t_dout != wdata_q[63:32]);
        done_d  = 1'b1;
        state_d = IDLE;
      end
`else
      WR_HI: begin
        err_d   = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // Parking cmp hi at all-ones first keeps mtimecmp from ever looking smaller than both old and new values
  always_comb begin
    bus.t_addr = 2'b00;
    bus.t_we   = 1'b0;
    bus.t_din  = '0;
    case (state_q)
      RD_HI1, RD_HI2: bus.t_addr = 2'b01;
      WR_HMAX: begin
        bus.t_addr = 2'b11;
        bus.t_we   = 1'b1;
        bus.t_din  = '1;
      end
      WR_LO: begin
        bus.t_addr = 2'b10;
        bus.t_we   = 1'b1;
        bus.t_din  = wdata_q[31:0];
      end
      WR_HI: begin
        bus.t_addr = 2'b11;
        bus.t_we   = 1'b1;
        bus.t_din  = wdata_q[63:32];
      end
`ifdef MTIMER_CLIENT_READBACK_EN
      VF_LO: bus.t_addr = 2'b10;
      VF_HI: bus.t_addr = 2'b11;
`endif
      default: ;
    endcase
  end
  assign bus.busy  = state_q != IDLE;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
endmodule
